ccd_line_emulator: RTL

Synthesizable CCD line-sensor plus ADC emulator. It replaces the fixed-value CCD stimulus on the monochrome camera bench and can also stand in for the sensor on hardware bring-up. It watches the design's `clk_ccd` shift clock and `rog_ccd` readout gate, both sampled in the `CLK` domain. It produces one `DATA_W`-bit pixel per shift-clock edge, following a line sequence of lead dummies, active pixels and trail dummies, with run-time-selectable test patterns and line/overrun status.

---
 rtl/ccd_emu_pkg.sv | 20 ++
 rtl/ccd_line_emulator_sync_rise.sv | 31 +++
 rtl/ccd_line_emulator.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ccd_emu_pkg.sv
// Shared encodings for the CCD line-sensor emulator.
package ccd_emu_pkg;

  // Test-pattern selections latched at each line start
  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_RAMP  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_DIAG  = 2'd3;

  // Line sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_LEAD,
    ST_ACTIVE,
    ST_TRAIL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ccd_line_emulator_sync_rise.sv
// Multi-flop synchronizer for an asynchronous level, followed by a
// rising-edge detector giving a single-cycle pulse in the clk domain.
module sync_rise #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Shift the async level through the synchronizer and keep its last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Pulse for one cycle when the synchronized level goes low to high
  always_comb begin
    rise_c = sync_q[SYNC_STAGES-1] & ~last_q;
  end

endmodule

// File: rtl/ccd_line_emulator.sv
// CCD line sensor + ADC emulator: one pixel per shift-clock edge through a
// lead-dummy / active / trail-dummy line, with selectable test patterns.
module ccd_line_emulator
  import ccd_emu_pkg::*;
#(
  parameter int unsigned DATA_W      = 11,
  parameter int unsigned PIXELS      = 2048,
  parameter int unsigned LEAD        = 32,
  parameter int unsigned TRAIL       = 14,
  parameter int unsigned DARK_LEVEL  = 0,
  parameter int unsigned CONST_VAL   = 'h0FF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                                     CLK,
  input  logic                                     RESET,
  input  logic                                     clk_ccd,
  input  logic                                     rog_ccd,
  input  logic [1:0]                               mode,
  output logic [DATA_W-1:0]                        ccd_data,
  output logic [15:0]                              line_cnt,
  output logic [$clog2(LEAD+PIXELS+TRAIL+1)-1:0]   pix_pos,
  output logic                                     line_done,
  output logic                                     overrun
);

  localparam int unsigned TOTAL = LEAD + PIXELS + TRAIL;
  localparam int unsigned POS_W = $clog2(TOTAL + 1);
  localparam logic [DATA_W-1:0] DARK = DATA_W'(DARK_LEVEL);

  logic shift_ev;
  logic rog_ev;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [DATA_W-1:0]  data_d;
  logic [POS_W-1:0]   pos_d;
  logic [15:0]        lc_d;
  logic               done_d;
  logic               ovr_d;

  logic [POS_W-1:0]   pos_adv;
  int unsigned        act_idx;
  logic               in_lead;
  logic               in_active;
  logic               is_last;
  state_t             region;
  logic [DATA_W-1:0]  pattern;
  logic [DATA_W-1:0]  pix_val;

  sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_sync_shift (
    .clk    (CLK),
    .rst    (RESET),
    .din    (clk_ccd),
    .rise_c (shift_ev)
  );

  sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rog (
    .clk    (CLK),
    .rst    (RESET),
    .din    (rog_ccd),
    .rise_c (rog_ev)
  );

  // Position the next shift would present, its region, and its pixel value
  always_comb begin
    pos_adv   = (state_q == ST_ARMED) ? '0 : pix_pos + POS_W'(1);
    act_idx   = 32'(pos_adv) - LEAD;
    in_lead   = 32'(pos_adv) < LEAD;
    in_active = !in_lead && (32'(pos_adv) < (LEAD + PIXELS));
    is_last   = 32'(pos_adv) == (TOTAL - 1);

    if (in_lead) begin
      region = ST_LEAD;
    end else if (in_active) begin
      region = ST_ACTIVE;
    end else begin
      region = ST_TRAIL;
    end

    pattern = DARK;
    case (mode_q)
      MODE_CONST: pattern = DATA_W'(CONST_VAL);
      MODE_RAMP:  pattern = DATA_W'(act_idx);
      MODE_CHECK: pattern = {DATA_W{act_idx[3] ^ line_cnt[0]}};
      MODE_DIAG:  pattern = DATA_W'(act_idx + 32'(line_cnt));
      default:    pattern = DARK;
    endcase

    pix_val = in_active ? pattern : DARK;
  end

  // Next-state and next-output logic; a readout gate overrides any shift
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    data_d  = ccd_data;
    pos_d   = pix_pos;
    lc_d    = line_cnt;
    ovr_d   = overrun;
    done_d  = 1'b0;

    if (rog_ev) begin
      state_d = ST_ARMED;
      lc_d    = line_cnt + 16'd1;
      mode_d  = mode;
      ovr_d   = 1'b0;
      data_d  = DARK;
      pos_d   = '0;
    end else if (shift_ev) begin
      case (state_q)
        ST_ARMED, ST_LEAD, ST_ACTIVE, ST_TRAIL: begin
          pos_d   = pos_adv;
          data_d  = pix_val;
          done_d  = is_last;
          state_d = is_last ? ST_DONE : region;
        end
        default: begin
          ovr_d = 1'b1;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_CONST;
      ccd_data  <= DARK;
      pix_pos   <= '0;
      line_cnt  <= '0;
      line_done <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      ccd_data  <= data_d;
      pix_pos   <= pos_d;
      line_cnt  <= lc_d;
      line_done <= done_d;
      overrun   <= ovr_d;
    end
  end

endmodule
